// File: rtl/o_serializer_pkg.sv
// o_serializer_pkg: shared state encoding, width limits and bit-order helper
package o_serializer_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;
  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] SHIFT = ST_SHIFT;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 16;
  function automatic logic [3:0] bit_idx(input logic [3:0] pos, input logic msb_first, input logic [4:0] width);
    return msb_first ? 4'(width - 5'd1 - 5'(pos)) : pos;
  endfunction
endpackage

// File: rtl/o_serializer_if.sv
// o_serializer_if: fabric-side word handshake, serial output and status flags
interface o_serializer_if #(parameter int WIDTH = 8);
  logic EN;
  logic [WIDTH-1:0] D;
  logic D_VALID;
  logic D_READY;
  logic Q;
  logic BUSY;
  logic UNDERRUN;
  logic UNDERRUN_CLR;
  modport master (output EN, D, D_VALID, UNDERRUN_CLR, input D_READY, Q, BUSY, UNDERRUN);
  modport slave (input EN, D, D_VALID, UNDERRUN_CLR, output D_READY, Q, BUSY, UNDERRUN);
endinterface

// File: rtl/o_serializer_hold.sv
// o_serializer_hold: one-entry holding register with valid/ready handshake
module o_serializer_hold
  import o_serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             xfer,
  output logic             d_ready,
  output logic             hold_v,
  output logic [WIDTH-1:0] hold
);
  logic             hold_v_q, hold_v_d, acc;
  logic [WIDTH-1:0] hold_q, hold_d;
  assign d_ready = RST & en & (~hold_v_q | xfer);
  assign acc = d_valid & d_ready;
  // capture a new word on accept; a transfer empties the slot unless refilled on the same edge
  always_comb begin
    hold_v_d = acc ? 1'b1 : xfer ? 1'b0 : hold_v_q;
    hold_d = acc ? d : hold_q;
  end
  // holding register state
  always_ff @(posedge CLK) begin
    if (!RST) begin
      hold_v_q <= 1'b0;
      hold_q <= '0;
    end else begin
      hold_v_q <= hold_v_d;
      hold_q <= hold_d;
    end
  end
  assign hold_v = hold_v_q;
  assign hold = hold_q;
endmodule

// File: rtl/o_serializer.sv
// o_serializer: parallel-to-serial output stage with holding register and underrun flag
module o_serializer
  import o_serializer_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_VALUE = 1'b0
) (
  input logic             CLK,
  input logic             RST,
  o_serializer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("o_serializer: WIDTH must be within 2..16");
  end
  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, hold;
  logic [15:0]      hold_x, sh_x;
  logic             q_q, q_d, und_q, und_d, hold_v, xfer, last;
  assign last = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
  assign xfer = hold_v && ((state_q == IDLE) || last);
  assign hold_x = 16'(hold);
  assign sh_x = 16'(sh_q);
  o_serializer_hold #(.WIDTH(WIDTH)) u_hold (
    .CLK     (CLK),
    .RST     (RST),
    .en      (bus.EN),
    .d       (bus.D),
    .d_valid (bus.D_VALID),
    .xfer    (xfer),
    .d_ready (bus.D_READY),
    .hold_v  (hold_v),
    .hold    (hold)
  );
  // shifter, bit counter and FSM: load on transfer, step through the word, fall back to idle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sh_d = sh_q;
    q_d = q_q;
    if (xfer) begin
      sh_d = hold;
      q_d = hold_x[bit_idx(4'd0, MSB_FIRST, 5'(WIDTH))];
      cnt_d = '0;
      state_d = SHIFT;
    end else if (last) begin
      q_d = IDLE_VALUE;
      cnt_d = '0;
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      q_d = sh_x[bit_idx(4'(cnt_q) + 4'd1, MSB_FIRST, 5'(WIDTH))];
      cnt_d = cnt_q + 1'b1;
    end
  end
  // sticky underrun: an empty word boundary while enabled sets it, and a set beats a clear
  always_comb und_d = (last & ~hold_v & bus.EN) | (und_q & ~bus.UNDERRUN_CLR);
  // state registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sh_q <= '0;
      q_q <= IDLE_VALUE;
      und_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      q_q <= q_d;
      und_q <= und_d;
    end
  end
  assign bus.Q = q_q;
  assign bus.BUSY = (state_q == SHIFT);
  assign bus.UNDERRUN = und_q;
endmodule

// File: tb/tb_o_serializer.sv
// tb_o_serializer: directed vector bench across three serializer configurations
module tb_o_serializer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  o_serializer_if #(.WIDTH(4)) if4 ();
  o_serializer_if #(.WIDTH(8)) if8 ();
  o_serializer_if #(.WIDTH(4)) if4i ();
  o_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_VALUE(1'b0)) u4 (.CLK(clk), .RST(rst), .bus(if4));
  o_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VALUE(1'b0)) u8 (.CLK(clk), .RST(rst), .bus(if8));
  o_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_VALUE(1'b1)) u4i (.CLK(clk), .RST(rst), .bus(if4i));
  typedef struct {
    logic       en;
    logic       v;
    logic [3:0] d;
    logic       clr;
    logic       rdy;
    logic       q;
    logic       busy;
    logic       und;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic en, logic v, logic [3:0] d, logic clr, logic rdy, logic q, logic busy, logic und);
    vec_t r;
    r.en = en; r.v = v; r.d = d; r.clr = clr;
    r.rdy = rdy; r.q = q; r.busy = busy; r.und = und;
    return r;
  endfunction
  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send8(input logic [7:0] w);
    if8.D = w;
    if8.D_VALID = 1'b1;
    tick();
    if8.D_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("w8 %h bit%0d q", w, i), if8.Q, w[i]);
      chk($sformatf("w8 %h bit%0d busy", w, i), if8.BUSY, 1'b1);
    end
    tick();
    chk("w8 end q", if8.Q, 1'b0);
    chk("w8 end busy", if8.BUSY, 1'b0);
    chk("w8 end und", if8.UNDERRUN, 1'b1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [3:0] w9;
    w9 = 4'h9;
    if4.EN = 1'b1; if4.D = '0; if4.D_VALID = 1'b0; if4.UNDERRUN_CLR = 1'b0;
    if8.EN = 1'b1; if8.D = '0; if8.D_VALID = 1'b0; if8.UNDERRUN_CLR = 1'b0;
    if4i.EN = 1'b1; if4i.D = '0; if4i.D_VALID = 1'b0; if4i.UNDERRUN_CLR = 1'b0;
    tick();
    tick();
    chk("rst q4", if4.Q, 1'b0);
    chk("rst busy4", if4.BUSY, 1'b0);
    chk("rst und4", if4.UNDERRUN, 1'b0);
    chk("rst rdy4", if4.D_READY, 1'b0);
    chk("rst rdy8", if8.D_READY, 1'b0);
    chk("rst q4i", if4i.Q, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle1 q c%0d", i), if4i.Q, 1'b1);
      chk($sformatf("idle1 und c%0d", i), if4i.UNDERRUN, 1'b0);
    end
    tbl.push_back(mk(1, 1, 4'hA, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'hA, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 1, 4'h5, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 0, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'h5, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h5, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'hC, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'hC, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'hC, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 4'hC, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hC, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 4'hC, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'hF, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'h8, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 4'h8, 0, 1, 1, 1, 0));
    tbl.push_back(mk(1, 0, 4'h8, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h8, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h8, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 4'h8, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'h8, 1, 1, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      if4.EN = tbl[i].en;
      if4.D_VALID = tbl[i].v;
      if4.D = tbl[i].d;
      if4.UNDERRUN_CLR = tbl[i].clr;
      #1;
      chk($sformatf("row%0d rdy", i), if4.D_READY, tbl[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d q", i), if4.Q, tbl[i].q);
      chk($sformatf("row%0d busy", i), if4.BUSY, tbl[i].busy);
      chk($sformatf("row%0d und", i), if4.UNDERRUN, tbl[i].und);
    end
    if4.UNDERRUN_CLR = 1'b0;
    send8(8'h01);
    send8(8'hB4);
    if4.EN = 1'b1;
    if4.D = 4'hA;
    if4.D_VALID = 1'b1;
    tick();
    if4.D = 4'h5;
    tick();
    if4.D_VALID = 1'b0;
    chk("mid q0", if4.Q, 1'b1);
    tick();
    chk("mid q1", if4.Q, 1'b0);
    tick();
    chk("mid q2", if4.Q, 1'b1);
    chk("mid held", u4.u_hold.hold_v_q, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid rst rdy", if4.D_READY, 1'b0);
    tick();
    chk("mid rst q", if4.Q, 1'b0);
    chk("mid rst busy", if4.BUSY, 1'b0);
    chk("mid rst hold_v", u4.u_hold.hold_v_q, 1'b0);
    chk("mid rst und", if4.UNDERRUN, 1'b0);
    rst = 1'b1;
    tick();
    chk("post rst q", if4.Q, 1'b0);
    chk("post rst busy", if4.BUSY, 1'b0);
    if4.D = w9;
    if4.D_VALID = 1'b1;
    tick();
    if4.D_VALID = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      tick();
      chk($sformatf("post rst bit%0d", i), if4.Q, w9[i]);
      chk($sformatf("post rst busy%0d", i), if4.BUSY, 1'b1);
    end
    tick();
    chk("post rst end q", if4.Q, 1'b0);
    chk("post rst end und", if4.UNDERRUN, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/o_serializer.md
# o_serializer

Parallel-to-serial output stage that sits directly upstream of the differential output buffer. It accepts WIDTH-bit words from fabric logic over a valid/ready handshake. It shifts each word out one bit per CLK cycle on a registered single-bit Q, which drives the buffer's single-ended input. A one-entry holding register lets consecutive words stream with no idle bit between them. An underrun is flagged when the stream is enabled but no word is available at a word boundary.

## Interface
Parameters:
- WIDTH, 8, word width in bits; legal range 2..16; out-of-range values raise an elaboration error.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_VALUE, 1'b0, level driven on Q when no word is being shifted.

Ports:
- CLK  input  1  serial bit clock; all logic is clocked on the rising edge.
- RST  input  1  reset; synchronous, active-low.
- EN  input  1  stream enable; also qualifies underrun detection.
- D  input  WIDTH  parallel word.
- D_VALID  input  1  D holds a valid word.
- D_READY  output  1  block can accept a word this cycle.
- Q  output  1  serial data, registered; connects to the output buffer input.
- BUSY  output  1  a word is currently being shifted.
- UNDERRUN  output  1  sticky underrun flag.
- UNDERRUN_CLR  input  1  clears UNDERRUN.

## Operation
- Accept: a word is captured into the holding register (hold, hold_v) on an edge where D_VALID and D_READY are both 1.
- D_READY = RST & EN & (!hold_v | xfer). It is combinational from registered state and RST, and never depends on D_VALID.
- xfer = hold_v & (state==IDLE | (state==SHIFT & cnt==WIDTH-1)).
- On xfer:
  - Q is loaded with the first bit of hold.
  - The shifter is loaded with the remaining WIDTH-1 bits.
  - cnt <= 0, state <= SHIFT.
  - hold_v <= 0, unless a new word is accepted on the same edge, in which case hold_v stays 1 with the new word.
- SHIFT with cnt<WIDTH-1: Q <= next bit in transmission order; cnt <= cnt+1.
- SHIFT with cnt==WIDTH-1 and !hold_v: state <= IDLE and Q <= IDLE_VALUE. If EN==1, UNDERRUN <= 1.
- IDLE: Q holds IDLE_VALUE. An empty IDLE state never sets UNDERRUN.
- EN==0:
  - No new words are accepted.
  - A word already in hold or in the shifter still drains completely.
  - Reaching IDLE with EN==0 is a clean stop and does not flag an underrun.
- UNDERRUN_CLR clears UNDERRUN. If a set and a clear occur on the same edge, the set wins.
- cnt width is $clog2(WIDTH). cnt never exceeds WIDTH-1.

## Timing
- Reset values (RST low at an edge): state=IDLE, Q=IDLE_VALUE, BUSY=0, UNDERRUN=0, hold_v=0, cnt=0. D_READY=0 while RST is low.
- Reset mid-word: the current word and the held word are discarded. Q returns to IDLE_VALUE on that edge.
- Latency from an idle block:
  - Accept at edge k.
  - First bit on Q after edge k+1.
  - Last bit on Q after edge k+WIDTH.
  - Q returns to IDLE_VALUE after edge k+WIDTH+1 if no further word arrives.
- Throughput: one word per WIDTH cycles with no gap bits, provided the next word is accepted before the edge on which cnt==WIDTH-1.
- BUSY = (state==SHIFT). It rises together with the first bit on Q and falls together with Q's return to IDLE_VALUE.
- UNDERRUN rises on the same edge on which Q returns to IDLE_VALUE.

## Structure
- o_serializer_pkg holds:
  - the state enum {IDLE, SHIFT};
  - WIDTH_MIN=2 and WIDTH_MAX=16;
  - a function that returns the bit-order index for a given count and MSB_FIRST setting.
- One sub-module, o_serializer_hold: the one-entry holding register with the valid/ready logic and the xfer input. The top level contains the shifter, counter, FSM and flags.

## Test plan
- WIDTH=4, MSB_FIRST=1, IDLE_VALUE=0, D=4'b1010 accepted at edge k -> Q = 1,0,1,0 after edges k+1..k+4; then 0; BUSY high for exactly 4 cycles; UNDERRUN=1 because EN=1.
- Back-to-back 4'hA then 4'h5, second word accepted while the first is shifting -> Q shows 1010 0101 with no gap; D_READY low only while hold is full.
- MSB_FIRST=0, WIDTH=8, D=8'h01 -> Q = 1 followed by seven 0s.
- EN dropped to 0 after one accept -> the word drains; D_READY=0; UNDERRUN stays 0. UNDERRUN_CLR and a new set on the same edge -> UNDERRUN stays 1.
- RST asserted at cnt=2 with a word held -> on that edge Q=IDLE_VALUE, BUSY=0, hold_v=0; after release the next accepted word starts at its first bit.
- IDLE_VALUE=1, no traffic for 20 cycles -> Q stays 1 and UNDERRUN stays 0.
